// File: rtl/mac_array_ctrl.sv
// mac_array_ctrl: job sequencer for the MAC array.
// Accepts one convolution job, handshakes a weight set from the preload
// buffer, pulses the array clear/load strobes, streams ifmap columns and
// flags every valid psum column. Owns every array control pin.
// Ports:
//   clk, rst_n                     clock / async active-low reset
//   start, *_cfg                   job request and configuration
//   busy, done, cfg_err            job status to the control unit
//   weight_valid/ready             weight-set handshake
//   ifmaps_valid/ready             ifmap column stream handshake
//   enable, operation, kernel_size array configuration (held for the job)
//   load_weight, load_ifmaps       one-cycle array strobes
//   ifmaps_input_valid             array shift-in qualifier
//   psum_valid, psum_col           output column flag and index
module mac_array_ctrl #(
  parameter int MAC_NUM = 256,
  parameter int COL_W   = 8,
  localparam int AW     = $clog2(MAC_NUM) + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [2:0]         kernel_size_cfg,
  input  logic [1:0]         operation_cfg,
  input  logic [AW-1:0]      active_mac_cfg,
  input  logic [COL_W-1:0]   ifmap_cols_cfg,
  output logic               busy,
  output logic               done,
  output logic               cfg_err,
  input  logic               weight_valid,
  output logic               weight_ready,
  input  logic               ifmaps_valid,
  output logic               ifmaps_ready,
  output logic [MAC_NUM-1:0] enable,
  output logic [1:0]         operation,
  output logic [4:0]         kernel_size,
  output logic               load_weight,
  output logic               load_ifmaps,
  output logic               ifmaps_input_valid,
  output logic               psum_valid,
  output logic [COL_W-1:0]   psum_col
);

  typedef enum logic [2:0] {IDLE, LOAD_W, CLEAR, STREAM, DRAIN} state_e;

  state_e             state_q, state_d;
  logic               busy_q, done_q, cfg_err_q, load_q, psum_valid_q;
  logic [MAC_NUM-1:0] enable_q;
  logic [1:0]         operation_q;
  logic [4:0]         kernel_size_q;
  logic [2:0]         k_q;
  logic [COL_W-1:0]   cols_q, b_q, psum_col_q;

  logic               cfg_ok, accept, beat, last_beat, psum_hit;
  logic [AW-1:0]      am_clamp;
  logic [MAC_NUM-1:0] en_mask;
  logic [4:0]         k_mask;
  logic [COL_W-1:0]   k_m1;

  // k in 1..5, at least one MAC, and enough columns for one full window
  assign cfg_ok = (kernel_size_cfg != 3'd0) && (kernel_size_cfg <= 3'd5) &&
                  (active_mac_cfg != '0) &&
                  (ifmap_cols_cfg >= COL_W'(kernel_size_cfg));
  assign accept = (state_q == IDLE) && start && cfg_ok;

  // Oversized active_mac requests saturate to the whole array
  assign am_clamp = (active_mac_cfg > AW'(MAC_NUM)) ? AW'(MAC_NUM) : active_mac_cfg;

  for (genvar i = 0; i < MAC_NUM; i++) begin : g_en
    assign en_mask[i] = (AW'(i) < am_clamp);
  end
  for (genvar i = 0; i < 5; i++) begin : g_k
    assign k_mask[i] = (3'(i) < kernel_size_cfg);
  end

  assign beat      = (state_q == STREAM) && ifmaps_valid;
  assign last_beat = beat && (b_q == cols_q - COL_W'(1));
  // The window is full once k columns have been shifted in
  assign k_m1      = COL_W'(k_q) - COL_W'(1);
  assign psum_hit  = beat && (b_q >= k_m1);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)       state_d = LOAD_W;
      LOAD_W:  if (weight_valid) state_d = CLEAR;
      CLEAR:                     state_d = STREAM;
      STREAM:  if (last_beat)    state_d = DRAIN;
      DRAIN:                     state_d = IDLE;
      default:                   state_d = IDLE;
    endcase
  end

  // Handshake outputs decoded straight from state
  always_comb begin
    weight_ready       = (state_q == LOAD_W);
    ifmaps_ready       = (state_q == STREAM);
    ifmaps_input_valid = (state_q == STREAM) && ifmaps_valid;
  end

  // Registered outputs, job config and beat counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      cfg_err_q     <= 1'b0;
      load_q        <= 1'b0;
      psum_valid_q  <= 1'b0;
      psum_col_q    <= '0;
      enable_q      <= '0;
      operation_q   <= '0;
      kernel_size_q <= '0;
      k_q           <= '0;
      cols_q        <= '0;
      b_q           <= '0;
    end else begin
      busy_q       <= (state_d != IDLE);
      done_q       <= last_beat;
      cfg_err_q    <= (state_q == IDLE) && start && !cfg_ok;
      load_q       <= (state_q == LOAD_W) && weight_valid;
      psum_valid_q <= psum_hit;
      psum_col_q   <= psum_hit ? (b_q - k_m1) : '0;
      if (accept) begin
        enable_q      <= en_mask;
        operation_q   <= operation_cfg;
        kernel_size_q <= k_mask;
        k_q           <= kernel_size_cfg;
        cols_q        <= ifmap_cols_cfg;
      end else if (state_d == IDLE) begin
        enable_q      <= '0;
        operation_q   <= '0;
        kernel_size_q <= '0;
      end
      if (state_q != STREAM) b_q <= '0;
      else if (beat)         b_q <= b_q + COL_W'(1);
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign cfg_err     = cfg_err_q;
  assign load_weight = load_q;
  assign load_ifmaps = load_q;
  assign psum_valid  = psum_valid_q;
  assign psum_col    = psum_col_q;
  assign enable      = enable_q;
  assign operation   = operation_q;
  assign kernel_size = kernel_size_q;

endmodule

// File: tb/tb_mac_array_ctrl.sv
// Directed bench for mac_array_ctrl: expected psum columns are queued as
// beats are driven and popped when psum_valid appears.
module tb_mac_array_ctrl;
  localparam int MAC_NUM = 256;
  localparam int COL_W   = 8;
  localparam int AW      = $clog2(MAC_NUM) + 1;

  logic               clk = 1'b0, rst_n = 1'b0;
  logic               start = 1'b0;
  logic [2:0]         kernel_size_cfg = '0;
  logic [1:0]         operation_cfg = '0;
  logic [AW-1:0]      active_mac_cfg = '0;
  logic [COL_W-1:0]   ifmap_cols_cfg = '0;
  logic               busy, done, cfg_err, weight_ready, ifmaps_ready;
  logic               weight_valid = 1'b0, ifmaps_valid = 1'b0;
  logic [MAC_NUM-1:0] enable;
  logic [1:0]         operation;
  logic [4:0]         kernel_size;
  logic               load_weight, load_ifmaps, ifmaps_input_valid, psum_valid;
  logic [COL_W-1:0]   psum_col;

  int n_assert = 0, n_fail = 0, psum_seen = 0;
  int q[$];

  mac_array_ctrl #(.MAC_NUM(MAC_NUM), .COL_W(COL_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .kernel_size_cfg(kernel_size_cfg), .operation_cfg(operation_cfg),
    .active_mac_cfg(active_mac_cfg), .ifmap_cols_cfg(ifmap_cols_cfg),
    .busy(busy), .done(done), .cfg_err(cfg_err),
    .weight_valid(weight_valid), .weight_ready(weight_ready),
    .ifmaps_valid(ifmaps_valid), .ifmaps_ready(ifmaps_ready),
    .enable(enable), .operation(operation), .kernel_size(kernel_size),
    .load_weight(load_weight), .load_ifmaps(load_ifmaps),
    .ifmaps_input_valid(ifmaps_input_valid),
    .psum_valid(psum_valid), .psum_col(psum_col)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [MAC_NUM-1:0] obs,
                     input logic [MAC_NUM-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every psum_valid must match the oldest queued column
  always @(negedge clk) begin
    if (rst_n && psum_valid) begin
      psum_seen++;
      chk("psum_pending", MAC_NUM'(q.size() != 0), 1);
      if (q.size() != 0) chk("psum_col", psum_col, q.pop_front());
    end
  end

  task automatic cyc(); @(posedge clk); #1; endtask
  task automatic smp(); @(negedge clk); #1; endtask

  task automatic idle_chk(input string tag);
    chk({tag, "_ctl"}, {busy, done, cfg_err, load_weight, load_ifmaps, psum_valid,
        weight_ready, ifmaps_ready, ifmaps_input_valid, operation, kernel_size,
        psum_col}, 0);
    chk({tag, "_en"}, enable, 0);
  endtask

  task automatic set_cfg(input int k, input int cols, input int am, input int op);
    kernel_size_cfg = 3'(k);
    ifmap_cols_cfg  = COL_W'(cols);
    active_mac_cfg  = AW'(am);
    operation_cfg   = 2'(op);
  endtask

  // One full job; called at posedge+1. poke re-asserts start during LOAD_W.
  task automatic run_job(input int k, input int cols, input int am, input int op,
                         input int wait_w, input bit toggle, input bit poke);
    logic [MAC_NUM-1:0] m;
    logic [4:0] km;
    int b, n0;
    m = '0;
    km = '0;
    for (int i = 0; i < MAC_NUM; i++) if (i < am) m[i] = 1'b1;
    for (int i = 0; i < 5; i++) if (i < k) km[i] = 1'b1;
    set_cfg(k, cols, am, op);
    start = 1'b1;
    cyc();
    start = 1'b0;
    smp();
    chk("acc_busy_wr", {busy, weight_ready, load_weight}, 3'b110);
    chk("acc_enable", enable, m);
    chk("acc_op_ks", {operation, kernel_size}, {2'(op), km});
    n0 = psum_seen;
    for (int w = 0; w < wait_w; w++) begin
      cyc();
      start = 1'b0;
      smp();
      chk("wait_w", {weight_ready, load_weight, load_ifmaps, busy}, 4'b1001);
      if (poke && w == 0) start = 1'b1;
    end
    weight_valid = 1'b1;
    cyc();
    weight_valid = 1'b0;
    start = 1'b0;
    smp();
    chk("clear", {weight_ready, load_weight, load_ifmaps, ifmaps_ready}, 4'b0110);
    b = 0;
    for (int c = 0; c < 200 && b < cols; c++) begin
      cyc();
      ifmaps_valid = toggle ? (c % 2 == 0) : 1'b1;
      if (ifmaps_valid && b >= k - 1) q.push_back(b - (k - 1));
      smp();
      chk("stream", {ifmaps_ready, ifmaps_input_valid, done, busy, load_weight},
          {1'b1, ifmaps_valid, 1'b0, 1'b1, 1'b0});
      if (ifmaps_valid) b++;
    end
    chk("stream_beats", b, cols);
    cyc();
    ifmaps_valid = 1'b0;
    smp();
    chk("drain", {done, psum_valid, busy, ifmaps_ready}, 4'b1110);
    chk("sb_empty", q.size(), 0);
    chk("psum_count", psum_seen - n0, cols - k + 1);
    cyc();
    smp();
    idle_chk("post_job");
    cyc();
  endtask

  task automatic bad(input int k, input int cols, input int am, input string tag);
    set_cfg(k, cols, am, 0);
    start = 1'b1;
    cyc();
    start = 1'b0;
    smp();
    chk(tag, {cfg_err, busy, weight_ready, load_weight, load_ifmaps}, 5'b10000);
    cyc();
    smp();
    idle_chk({tag, "_after"});
    cyc();
  endtask

  initial begin
    repeat (3) cyc();
    smp();
    idle_chk("reset");
    cyc();
    rst_n = 1'b1;
    cyc();

    run_job(3, 6, 4, 1, 0, 1'b0, 1'b0);   // basic job
    run_job(3, 6, 4, 2, 2, 1'b1, 1'b0);   // stalled stream
    bad(0, 6, 4, "bad_k0");
    bad(6, 6, 4, "bad_k6");
    bad(3, 2, 4, "bad_cols");
    bad(2, 6, 0, "bad_am0");
    run_job(2, 5, 100, 3, 20, 1'b0, 1'b0); // long weight wait
    run_job(5, 7, 256, 1, 1, 1'b0, 1'b0); // widest kernel

    // Abort mid-STREAM with reset
    set_cfg(3, 6, 4, 1);
    start = 1'b1;
    cyc();
    start = 1'b0;
    weight_valid = 1'b1;
    cyc();
    weight_valid = 1'b0;
    cyc();
    ifmaps_valid = 1'b1;
    cyc();
    cyc();
    smp();
    chk("pre_abort", {busy, ifmaps_ready}, 2'b11);
    rst_n = 1'b0;
    ifmaps_valid = 1'b0;
    #1;
    idle_chk("abort_async");
    cyc();
    smp();
    idle_chk("abort_hold");
    cyc();
    rst_n = 1'b1;
    cyc();
    run_job(3, 6, 4, 1, 0, 1'b0, 1'b0);   // clean restart

    run_job(1, 1, 300, 0, 3, 1'b0, 1'b1); // clamp, k=1, start while busy
    smp();
    idle_chk("poke_ignored");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/mac_array_ctrl.md
# mac_array_ctrl

Sequencer for the MAC array: accepts one convolution job (kernel size, operation, active MAC count, input column count), loads weights from the preload buffer, clears and streams ifmap columns from the AXI-Stream preload path, and flags valid partial-sum columns on the array output. It sits between the control unit (job start/done) and the MAC array control pins, and owns every array control signal.

## Interface
- MAC_NUM, 256, number of MACs in the array
- COL_W, 8, width of the ifmap column counter
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  job request, sampled only in IDLE
- kernel_size_cfg  in  3  kernel edge length, legal 1..5
- operation_cfg  in  2  operation code passed to the array
- active_mac_cfg  in  $clog2(MAC_NUM)+1  number of MACs to enable, legal 1..MAC_NUM
- ifmap_cols_cfg  in  COL_W  ifmap columns to stream, legal kernel_size_cfg..2^COL_W-1
- busy  out  1  high from accepted start to done, inclusive
- done  out  1  one-cycle pulse at job end
- cfg_err  out  1  one-cycle pulse on rejected start
- weight_valid  in  1  preload buffer holds a full weight set
- weight_ready  out  1  controller accepts the weight set
- ifmaps_valid  in  1  ifmap column beat available on the stream
- ifmaps_ready  out  1  controller accepts the ifmap beat
- enable  out  MAC_NUM  per-MAC enable to the array
- operation  out  2  array operation code
- kernel_size  out  5  thermometer kernel mask to the array (k ones from bit 0)
- load_weight  out  1  array weight-load strobe
- load_ifmaps  out  1  array ifmap window clear/load strobe
- ifmaps_input_valid  out  1  array shift-in qualifier
- psum_valid  out  1  array psum_out holds a valid output column
- psum_col  out  COL_W  index of the output column flagged by psum_valid

## Operation
- States: IDLE, LOAD_W, CLEAR, STREAM, DRAIN.
- IDLE: start=1 with legal config -> latch all cfg, go LOAD_W. An illegal config (k=0, k>5, active_mac=0, ifmap_cols<k) pulses cfg_err next cycle and stays in IDLE. An active_mac value greater than MAC_NUM is clamped to MAC_NUM and is not an error.
- LOAD_W: weight_ready=1. When weight_valid&weight_ready -> CLEAR.
- CLEAR: load_weight=1 and load_ifmaps=1 for exactly one cycle -> STREAM.
- STREAM:
  - ifmaps_ready=1 and ifmaps_input_valid=ifmaps_valid.
  - Each accepted beat increments beat counter b (starts at 0).
  - A beat with b>=k-1 schedules psum_valid on the next cycle, with psum_col=b-(k-1).
  - An accepted beat with b=ifmap_cols-1 -> DRAIN.
  - ifmaps_valid=0 stalls: counters hold and no shift occurs.
- DRAIN: one cycle. The last psum_valid and done are asserted together -> IDLE.
- Outputs held for the whole job, cleared to 0 in IDLE:
  - enable: low active_mac bits set.
  - operation and kernel_size: latched values.
- Output columns per job = ifmap_cols-k+1, with psum_col running 0..ifmap_cols-k.
- start while busy is ignored, with no error.

## Timing
- All outputs are registered except weight_ready, ifmaps_ready and ifmaps_input_valid, which are decoded from the state register and inputs.
- Reset value of every output is 0, state is IDLE and counters are 0. Reset asserted mid-job aborts immediately with no done pulse.
- start at cycle T -> busy, enable, operation and kernel_size valid from T+1; weight_ready high from T+1.
- Weight handshake at cycle W -> load_weight and load_ifmaps high at W+1 only; ifmaps_ready high from W+2.
- Beat accepted at cycle t with b>=k-1 -> psum_valid at t+1. This matches the one-cycle array MAC latency.
- Last beat at cycle L -> DRAIN at L+1, with done, last psum_valid and busy high; busy=0 at L+2.
- k=1 gives a valid psum after every beat.
- Back-to-back jobs: start is accepted earliest one cycle after done.

## Test plan
- k=3, ifmap_cols=6, active_mac=4, ifmaps_valid always 1 -> enable=0x...0F; load strobes one cycle; psum_valid on 4 consecutive cycles with psum_col 0,1,2,3; done coincident with the 4th; busy duration = 1+wait+1+6+1.
- Same job with ifmaps_valid toggled 1,0,1,0 -> psum_valid only after accepted beats, still exactly 4 pulses, psum_col gaps-free.
- Illegal config starts k=0, k=6, and ifmap_cols=2 with k=3 -> cfg_err one-cycle pulse each time; busy stays 0; no strobes.
- weight_valid held low 20 cycles -> controller stays in LOAD_W with weight_ready=1 and no load strobes; proceeds one cycle after weight_valid rises.
- Reset asserted mid-STREAM, then a new start -> all outputs 0 during reset, no done pulse; the new job runs cleanly with psum_col restarting at 0.
- k=1, ifmap_cols=1, active_mac=MAC_NUM+ (clamped), start asserted again while busy -> single psum_valid with psum_col=0; all enable bits set; the second start is ignored.
